// File: rtl/pe_buffer_pingpong_sched_if.sv
// Bi-side write bus of the ping-pong PE input buffer: per-requester strobes and
// row ids toward the scheduler, buffer_ready back to the writers.
interface pe_buffer_pingpong_sched_if #(
    parameter int Bi          = 4,
    parameter int ROWID_WIDTH = 6
);
    logic [Bi-1:0]             bi_we;
    logic [Bi*ROWID_WIDTH-1:0] bi_row_id;
    logic                      buffer_ready;

    modport master (output bi_we, output bi_row_id, input buffer_ready);
    modport slave  (input bi_we, input bi_row_id, output buffer_ready);
endinterface

// File: rtl/pe_buffer_pingpong_sched.sv
// Ping-pong scheduler for the two-bank PE input buffer: counts row writes into the
// fill bank, waits for the PE array to drain the other bank, then swaps banks.
module pe_buffer_pingpong_sched #(
    parameter int Ih            = 29,
    parameter int Iw            = 7,
    parameter int HOUT          = 56,
    parameter int Bi            = 4,
    parameter int ROWID_WIDTH   = 6,
    parameter int GROUPS        = 8,
    parameter int GROUPID_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    pe_buffer_pingpong_sched_if.slave     bus,
    input  logic                          compute_idle,
    input  logic                          ram_output_blocked,
    output logic                          pe_buffer_switch,
    output logic [Ih-1:0]                 row_done_mask,
    output logic [GROUPID_WIDTH-1:0]      group_id,
    output logic                          swap_pulse,
    output logic                          all_done,
    output logic                          err_overflow,
    output logic                          err_collision,
    output logic                          err_row_range
);
    localparam int WPR = HOUT / Iw;
    localparam int CW  = $clog2(WPR + 1);
    localparam int IW  = $clog2(Ih);

    typedef enum logic [2:0] {
        IDLE, FILL, WAIT_DRAIN, SWAP, FINISH, DONE
    } state_t;

    state_t                   r_state, w_nxt;
    logic [CW-1:0]            r_cnt [Ih];
    logic [CW-1:0]            w_cnt_nxt [Ih];
    logic [Ih-1:0]            r_mask, w_mask_nxt;
    logic [ROWID_WIDTH-1:0]   w_rid [Bi];
    logic [Bi-1:0]            w_lose;
    logic [Ih-1:0]            w_inc;
    logic                     w_ovf, w_col, w_rng;
    logic                     w_start_acc, w_clr, w_all, w_last_grp;
    logic                     r_ready, r_switch, r_swap, r_done;
    logic                     r_ovf, r_col, r_rng;
    logic [GROUPID_WIDTH-1:0] r_gid;

    // A requester loses a row when a lower-index requester targets the same row.
    always_comb begin
        for (int k = 0; k < Bi; k++) begin
            w_rid[k]  = bus.bi_row_id[k*ROWID_WIDTH +: ROWID_WIDTH];
        end
        for (int k = 0; k < Bi; k++) begin
            w_lose[k] = 1'b0;
            for (int j = 0; j < Bi; j++) begin
                if (j < k && bus.bi_we[j] && w_rid[j] == w_rid[k]) begin
                    w_lose[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_inc = '0;
        w_ovf = 1'b0;
        w_col = 1'b0;
        w_rng = 1'b0;
        for (int k = 0; k < Bi; k++) begin
            if (bus.bi_we[k]) begin
                if (r_state != FILL) begin
                    w_ovf = 1'b1;
                end
                if (int'(w_rid[k]) >= Ih) begin
                    w_rng = 1'b1;
                end else if (w_lose[k]) begin
                    w_col = 1'b1;
                end else if (r_state == FILL && r_cnt[w_rid[k][IW-1:0]] != CW'(WPR)) begin
                    w_inc[w_rid[k][IW-1:0]] = 1'b1;
                end else begin
                    w_ovf = 1'b1;
                end
            end
        end
    end

    assign w_start_acc = start && (r_state == IDLE || r_state == DONE);
    assign w_clr       = w_start_acc || (r_state == SWAP);
    assign w_last_grp  = (r_gid == GROUPID_WIDTH'(GROUPS - 1));

    always_comb begin
        for (int r = 0; r < Ih; r++) begin
            w_cnt_nxt[r]  = w_clr ? '0 : r_cnt[r] + CW'(w_inc[r]);
            w_mask_nxt[r] = (w_cnt_nxt[r] == CW'(WPR));
        end
    end

    assign w_all = &w_mask_nxt;

    // The fill-complete decision uses the next mask so it leaves FILL on the same
    // edge that makes the registered mask all ones.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:       if (start) w_nxt = FILL;
            FILL:       if (w_all) w_nxt = WAIT_DRAIN;
            WAIT_DRAIN: if (compute_idle && !ram_output_blocked) w_nxt = SWAP;
            SWAP:       w_nxt = w_last_grp ? FINISH : FILL;
            FINISH:     if (compute_idle) w_nxt = DONE;
            DONE:       if (start) w_nxt = FILL;
            default:    w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_mask   <= '0;
            r_ready  <= 1'b0;
            r_switch <= 1'b0;
            r_swap   <= 1'b0;
            r_done   <= 1'b0;
            r_gid    <= '0;
            r_ovf    <= 1'b0;
            r_col    <= 1'b0;
            r_rng    <= 1'b0;
            for (int r = 0; r < Ih; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            r_state <= w_nxt;
            r_mask  <= w_mask_nxt;
            r_ready <= (w_nxt == FILL);
            r_swap  <= (w_nxt == SWAP);
            r_done  <= (w_nxt == DONE);
            for (int r = 0; r < Ih; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            if (w_start_acc) begin
                r_gid <= '0;
                r_ovf <= 1'b0;
                r_col <= 1'b0;
                r_rng <= 1'b0;
            end else begin
                if (r_state == SWAP && !w_last_grp) begin
                    r_gid <= r_gid + 1'b1;
                end
                r_ovf <= r_ovf | w_ovf;
                r_col <= r_col | w_col;
                r_rng <= r_rng | w_rng;
            end
            if (r_state == SWAP) begin
                r_switch <= ~r_switch;
            end
        end
    end

    assign bus.buffer_ready = r_ready;
    assign pe_buffer_switch = r_switch;
    assign row_done_mask    = r_mask;
    assign group_id         = r_gid;
    assign swap_pulse       = r_swap;
    assign all_done         = r_done;
    assign err_overflow     = r_ovf;
    assign err_collision    = r_col;
    assign err_row_range    = r_rng;
endmodule

// File: doc/pe_buffer_pingpong_sched.md
Name: pe_buffer_pingpong_sched

Overview:
- Scheduler for the two-bank PE input buffer (Ih row FIFOs per bank).
- Counts Bi row writes into the fill bank and detects when every row holds a full group.
- Waits until the PE array has drained the other bank and output RAM is unblocked, then toggles pe_buffer_switch.
- Owns buffer_ready toward pe_datain_ctrl and sequences a layer of GROUPS groups.

Parameters:
Ih, 29, rows per PE buffer bank
Iw, 7, pixels per FIFO word
HOUT, 56, output row width; words per row WPR = HOUT/Iw = 8
Bi, 4, number of Bi write requesters
ROWID_WIDTH, 6, row-id width per requester
GROUPS, 8, groups per layer
GROUPID_WIDTH, 8, group counter width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a layer
bi_we  in  Bi  per-requester FIFO write strobe
bi_row_id  in  Bi*ROWID_WIDTH  row id; requester k at bits [k*ROWID_WIDTH +: ROWID_WIDTH]
compute_idle  in  1  PE array not reading and drain bank empty
ram_output_blocked  in  1  previous conv result not yet consumed
pe_buffer_switch  out  1  0: Bi fills bank0, PE reads bank1; 1: the reverse
buffer_ready  out  1  Bi writes are accepted
row_done_mask  out  Ih  bit r = row r holds WPR words
group_id  out  GROUPID_WIDTH  index of the group being filled
swap_pulse  out  1  one cycle, coincides with the bank toggle
all_done  out  1  layer finished; held high
err_overflow  out  1  sticky: write to a full row or while not ready
err_collision  out  1  sticky: two or more requesters hit the same row in one cycle
err_row_range  out  1  sticky: write with row id >= Ih

Behaviour:
- Reset values: state IDLE, all outputs 0, all row counters 0. Reset mid-operation aborts immediately to these values.
- Row counters: Ih counters, width clog2(WPR+1).
- A write is accepted when all of the following hold: bi_we[k]=1, state FILL, row id < Ih, row count < WPR, and k is the lowest-index requester targeting that row this cycle.
  - Each accepted write increments its row counter by 1.
  - Distinct rows in the same cycle all count.
  - Losing requesters on a shared row set err_collision and are not counted.
- Rejections:
  - row id >= Ih: err_row_range.
  - Row already at WPR, or state is not FILL: err_overflow.
  - Error flags clear only on rstn or start.
- States:
  - IDLE: start -> FILL. Clears counters, group_id=0, all_done=0 and error flags.
  - FILL: buffer_ready=1. When row_done_mask is all ones (registered, visible the cycle after the last accepted write) -> WAIT_DRAIN. buffer_ready drops in the same cycle.
  - WAIT_DRAIN: when compute_idle=1 and ram_output_blocked=0 -> SWAP. Otherwise hold; simultaneous deassertion simply keeps waiting.
  - SWAP (exactly 1 cycle): swap_pulse=1 and counters clear. pe_buffer_switch toggles at the clock edge ending SWAP.
    - If group_id == GROUPS-1 -> FINISH.
    - Otherwise group_id+1 -> FILL.
  - FINISH: when compute_idle=1 -> DONE.
  - DONE: all_done=1. start -> FILL with a fresh layer. pe_buffer_switch is not reset by start.
- start is ignored outside IDLE and DONE.
- group_id wraps modulo 2^GROUPID_WIDTH. GROUPS must be ≤ 2^GROUPID_WIDTH.
- The first group swaps with no delay if compute_idle=1, so latency from the last write to swap_pulse is 2 cycles minimum.
- buffer_ready and all state outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
- Reset, start, then 29 rows × 8 writes from requester 0 with compute_idle=1 and blocked=0 -> buffer_ready low 1 cycle after the 232nd write; swap_pulse 2 cycles after it; pe_buffer_switch=1; group_id=1; counters 0.
- Same fill with ram_output_blocked=1 held for 10 cycles -> state stays WAIT_DRAIN, no swap_pulse; swap_pulse 2 cycles after blocked drops.
- Requesters 0 and 2 both write row 5 in one cycle -> row 5 count +1 only; err_collision=1; other rows unaffected.
- Ninth write to row 3, plus a write with row id 40 -> both writes uncounted; err_overflow=1, err_row_range=1; row 3 count stays 8.
- GROUPS=8 full layer -> 8 swap_pulses, switch alternates and ends at 0; all_done rises once compute_idle=1 after the 8th swap; start restarts with group_id=0.
- rstn asserted mid-FILL with 100 writes counted -> all outputs 0 and counters 0 immediately; after release, start is required before buffer_ready rises.
